// File: rtl/core_types_pkg.sv
// Shared types for the fetch front-end: branch-unit command bundle,
// fetch-queue entry layout and the canonical NOP encoding.
package core_types_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        flush;
    logic        hold;
    logic        branch;
    logic        bypass;
    logic [31:0] PCnext;
    logic [31:0] PCcurrent;
  } branching_out_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

  // Absolute target for bypass, otherwise PC-relative with 32-bit wrap-around.
  function automatic logic [31:0] redirect_target(input branching_out_t bo);
    return bo.bypass ? bo.PCnext : (bo.PCnext + bo.PCcurrent);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if;

  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemGnt,
    input  imemRvalid,
    input  imemRdata
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemGnt,
    output imemRvalid,
    output imemRdata
  );

endinterface

// File: rtl/fetch_unit_queue.sv
// Fetch queue: circular buffer of fetch entries. Entries are reserved in
// request order, filled in response order and popped from the head. The head
// view already reflects a fill landing this cycle so the IF/DEC register can
// capture a response without an extra bubble.
module fetch_queue
  import core_types_pkg::*;
#(
  parameter  int FQ_DEPTH = 2,
  localparam int AW       = $clog2(FQ_DEPTH),
  localparam int CW       = $clog2(FQ_DEPTH + 1)
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic          clear_i,
  input  logic          reserve_i,
  input  logic [31:0]   reserve_pc_i,
  input  logic          fill_i,
  input  logic [31:0]   fill_instr_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] unfilled_o,
  output fetch_entry_t  head_o,
  output logic          head_ready_o
);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW-1:0] fill_q, fill_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] unf_q, unf_d;
  fetch_entry_t  entries_q [FQ_DEPTH];
  fetch_entry_t  entries_d [FQ_DEPTH];
  logic          fill_hits_head;

  // Next-state for pointers, occupancy counters and entry storage.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    fill_d    = fill_q;
    count_d   = count_q;
    unf_d     = unf_q;
    entries_d = entries_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
      unf_d   = '0;
    end else begin
      if (reserve_i) begin
        entries_d[tail_q] = '{pc: reserve_pc_i, instr: NOP_INSTR, filled: 1'b0};
        tail_d            = tail_q + AW'(1);
      end
      if (fill_i) begin
        entries_d[fill_q].instr  = fill_instr_i;
        entries_d[fill_q].filled = 1'b1;
        fill_d                   = fill_q + AW'(1);
      end
      if (pop_i) begin
        head_d = head_q + AW'(1);
      end
      count_d = count_q + CW'(reserve_i) - CW'(pop_i);
      unf_d   = unf_q + CW'(reserve_i) - CW'(fill_i);
    end
  end

  // Head view, including a response that fills the head entry this cycle.
  always_comb begin
    fill_hits_head = fill_i && (unf_q != '0) && (fill_q == head_q);
    head_o         = entries_q[head_q];
    if (fill_hits_head) begin
      head_o.instr  = fill_instr_i;
      head_o.filled = 1'b1;
    end
    head_ready_o = (count_q != '0) && head_o.filled;
    count_o      = count_q;
    unfilled_o   = unf_q;
  end

  // Control state; cleared by reset.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      unf_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      unf_q   <= unf_d;
    end
  end

  // Entry storage; contents are only meaningful behind the pointers.
  always_ff @(posedge Clock) begin
    entries_q <= entries_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order requests to
// instruction memory, discards responses belonging to squashed requests and
// drives the IF/DEC register seen by decode and the branch unit.
module fetch_unit
  import core_types_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic           Clock,
  input  logic           nReset,
  input  branching_out_t branching_out,
  fetch_unit_if.master   imem,
  output logic           validIF,
  output logic [31:0]    instrIF,
  output logic [31:0]    PCIF
);

  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          valid_if_q, valid_if_d;
  logic [31:0]   instr_if_q, instr_if_d;
  logic [31:0]   pc_if_q, pc_if_d;

  logic          redirect;
  logic          jump;
  logic [31:0]   target;
  logic          req;
  logic          grant;
  logic          rsp_drop;
  logic          rsp_fill;
  logic          pop;
  logic [CW-1:0] q_count;
  logic [CW-1:0] q_unfilled;
  fetch_entry_t  q_head;
  logic          q_head_ready;

  // Request, response-steering and pop decisions for this cycle.
  always_comb begin
    redirect = branching_out.flush | branching_out.branch | branching_out.bypass;
    jump     = branching_out.branch | branching_out.bypass;
    target   = redirect_target(branching_out);
    req      = !redirect && (q_count < CW'(FQ_DEPTH));
    grant    = req && imem.imemGnt;
    rsp_drop = imem.imemRvalid && (drop_cnt_q != '0);
    rsp_fill = imem.imemRvalid && (drop_cnt_q == '0) && !redirect;
    pop      = !redirect && !branching_out.hold && q_head_ready;
  end

  assign imem.imemReq  = req;
  assign imem.imemAddr = pc_q;

  fetch_queue #(
    .FQ_DEPTH (FQ_DEPTH)
  ) u_queue (
    .Clock        (Clock),
    .nReset       (nReset),
    .clear_i      (redirect),
    .reserve_i    (grant),
    .reserve_pc_i (pc_q),
    .fill_i       (rsp_fill),
    .fill_instr_i (imem.imemRdata),
    .pop_i        (pop),
    .count_o      (q_count),
    .unfilled_o   (q_unfilled),
    .head_o       (q_head),
    .head_ready_o (q_head_ready)
  );

  // Next PC, stale-response counter and IF/DEC register contents.
  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    valid_if_d = valid_if_q;
    instr_if_d = instr_if_q;
    pc_if_d    = pc_if_q;
    if (redirect) begin
      if (jump) begin
        pc_d = target;
      end
      // Everything still in flight for the squashed queue becomes stale; a
      // response arriving right now is one of them and is consumed here.
      drop_cnt_d = drop_cnt_q + q_unfilled - CW'(imem.imemRvalid);
      valid_if_d = 1'b0;
      instr_if_d = NOP_INSTR;
    end else begin
      if (grant) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (!branching_out.hold) begin
        if (q_head_ready) begin
          valid_if_d = 1'b1;
          instr_if_d = q_head.instr;
          pc_if_d    = q_head.pc;
        end else begin
          valid_if_d = 1'b0;
          instr_if_d = NOP_INSTR;
        end
      end
    end
  end

  // PC, drop counter and IF/DEC register.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
      valid_if_q <= 1'b0;
      instr_if_q <= NOP_INSTR;
      pc_if_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
      valid_if_q <= valid_if_d;
      instr_if_q <= instr_if_d;
      pc_if_q    <= pc_if_d;
    end
  end

  assign validIF = valid_if_q;
  assign instrIF = instr_if_q;
  assign PCIF    = pc_if_q;

  // A response must always belong to a stale or a reserved, unfilled request.
  a_rsp_expected: assert property (@(posedge Clock) disable iff (!nReset)
    imem.imemRvalid |-> ((drop_cnt_q != '0) || (q_unfilled != '0)))
    else $error("fetch_unit: imem response with no request outstanding");

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order memory model.
module tb_fetch_unit;
  import core_types_pkg::*;

  logic           Clock;
  logic           nReset;
  branching_out_t bo;
  logic           validIF;
  logic [31:0]    instrIF;
  logic [31:0]    PCIF;

  fetch_unit_if imem_bus ();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (2)
  ) dut (
    .Clock         (Clock),
    .nReset        (nReset),
    .branching_out (bo),
    .imem          (imem_bus),
    .validIF       (validIF),
    .instrIF       (instrIF),
    .PCIF          (PCIF)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int lat    = 1;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;
  mreq_t mq[$];

  typedef struct {
    logic        flush;
    logic        branch;
    logic        bypass;
    logic [31:0] pcn;
    logic [31:0] pcc;
    logic [31:0] exp;
    string       name;
  } rvec_t;
  rvec_t tbl [6];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h0050_0093 ^ (a << 12);
  endfunction

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory model: records grants at the edge, answers lat cycles later.
  initial begin
    imem_bus.imemRvalid = 1'b0;
    imem_bus.imemRdata  = '0;
    forever begin
      @(posedge Clock);
      if (!nReset) mq.delete();
      else if (imem_bus.imemReq && imem_bus.imemGnt)
        mq.push_back('{due: cyc + lat, addr: imem_bus.imemAddr});
      cyc++;
      #1;
      if (nReset && mq.size() > 0 && mq[0].due <= cyc) begin
        imem_bus.imemRvalid = 1'b1;
        imem_bus.imemRdata  = instr_of(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_bus.imemRvalid = 1'b0;
        imem_bus.imemRdata  = '0;
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    int n;
    n = 0;
    while (validIF !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_valid"}, 32'(validIF), 32'd1);
    chk({name, "_pc"}, PCIF, exp_pc);
    chk({name, "_instr"}, instrIF, instr_of(exp_pc));
  endtask

  // Fresh start with a 3-cycle memory, two requests in flight, then redirect.
  task automatic fresh_redirect(input string name, input logic fl, input logic br,
                                input logic by, input logic [31:0] pcn,
                                input logic [31:0] pcc, input logic [31:0] exp);
    nReset = 1'b0;
    bo     = '0;
    lat    = 3;
    tick();
    tick();
    nReset = 1'b1;
    tick();
    tick();
    #1;
    chk({name, "_full_req"}, 32'(imem_bus.imemReq), 32'd0);
    bo.flush     = fl;
    bo.branch    = br;
    bo.bypass    = by;
    bo.PCnext    = pcn;
    bo.PCcurrent = pcc;
    tick();
    bo = '0;
    #1;
    chk({name, "_v0"}, 32'(validIF), 32'd0);
    chk({name, "_addr"}, imem_bus.imemAddr, exp);
    wait_valid(name, exp);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0020, 32'h0000_0120, "br_rel"};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_0044, 32'h0000_2000, "bypass"};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0008, 32'h0000_0300, "br_bypass"};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0000_0010, "br_wrap"};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FF00, 32'h0000_0400, 32'h0000_0300, "br_neg"};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0040, 32'h0000_0080, "flush_br"};

    nReset           = 1'b0;
    bo               = '0;
    imem_bus.imemGnt = 1'b1;
    lat              = 1;
    tick();
    tick();
    chk("rst_valid", 32'(validIF), 32'd0);
    chk("rst_instr", instrIF, NOP_INSTR);
    chk("rst_pc", PCIF, 32'd0);

    // Reset release and first instruction.
    nReset = 1'b1;
    #1;
    chk("first_req", 32'(imem_bus.imemReq), 32'd1);
    chk("first_addr", imem_bus.imemAddr, 32'd0);
    tick();
    chk("first_v0", 32'(validIF), 32'd0);
    tick();
    chk("first_valid", 32'(validIF), 32'd1);
    chk("first_instr", instrIF, 32'h0050_0093);
    chk("first_pc", PCIF, 32'd0);

    // Zero-bubble streaming.
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("stream_valid", 32'(validIF), 32'd1);
      chk("stream_pc", PCIF, 32'(4 * k));
    end

    // Hold for three cycles while the queue fills.
    bo.hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("hold_valid", 32'(validIF), 32'd1);
      chk("hold_pc", PCIF, 32'd12);
      chk("hold_instr", instrIF, instr_of(32'd12));
      chk("hold_req", 32'(imem_bus.imemReq), 32'd0);
      if (k == 2) bo.hold = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_hold_valid", 32'(validIF), 32'd1);
      chk("post_hold_pc", PCIF, 32'd16 + 32'(4 * k));
    end

    // Redirect vectors during 1-cycle streaming.
    for (int i = 0; i < 6; i++) begin
      bo.flush     = tbl[i].flush;
      bo.branch    = tbl[i].branch;
      bo.bypass    = tbl[i].bypass;
      bo.PCnext    = tbl[i].pcn;
      bo.PCcurrent = tbl[i].pcc;
      #1;
      chk({tbl[i].name, "_req_blocked"}, 32'(imem_bus.imemReq), 32'd0);
      tick();
      bo = '0;
      #1;
      chk({tbl[i].name, "_v0"}, 32'(validIF), 32'd0);
      chk({tbl[i].name, "_addr"}, imem_bus.imemAddr, tbl[i].exp);
      chk({tbl[i].name, "_req"}, 32'(imem_bus.imemReq), 32'd1);
      wait_valid(tbl[i].name, tbl[i].exp);
      tick();
      chk({tbl[i].name, "_next_pc"}, PCIF, tbl[i].exp + 32'd4);
    end

    // Stale responses with a slow memory.
    fresh_redirect("bypass_slow", 1'b0, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_0000, 32'h0000_2000);
    fresh_redirect("flush_slow", 1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h0000_0500, 32'h0000_0008);

    // Reset asserted between edges mid-stream.
    nReset = 1'b0;
    lat    = 1;
    tick();
    tick();
    nReset = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_rst_pc", PCIF, 32'd4);
    nReset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(validIF), 32'd0);
    chk("async_rst_instr", instrIF, NOP_INSTR);
    chk("async_rst_pc", PCIF, 32'd0);
    imem_bus.imemGnt = 1'b0;
    tick();
    nReset = 1'b1;
    #1;
    chk("rerst_addr", imem_bus.imemAddr, 32'd0);
    tick();
    #1;
    chk("nogrant_addr", imem_bus.imemAddr, 32'd0);
    chk("nogrant_req", 32'(imem_bus.imemReq), 32'd1);
    chk("nogrant_valid", 32'(validIF), 32'd0);
    imem_bus.imemGnt = 1'b1;
    wait_valid("rerst", 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
